home_inventory_event_engine: RTL

Parametrised successor to the per-channel event detector in the sensing datapath. It takes NCH channel samples per `sample_valid` strobe and detects threshold crossings with hysteresis re-arm and a per-channel holdoff. It keeps saturating counters, per-channel delta and timestamp registers, and a global last timestamp, and it serialises every detected event into a valid/ready event FIFO so that firmware or DMA can drain an ordered event log. Lost or coalesced events are counted.

---
 rtl/home_inventory_event_engine.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/home_inventory_event_engine.sv
// home_inventory_event_engine: per-channel threshold event detector with
// hysteresis re-arm, holdoff, saturating counters, timestamp/delta capture and
// an ordered valid/ready event FIFO fed by a lowest-index-first serialiser.

// Per-channel detector: arm/holdoff/history state, hit counter, delta and
// timestamp capture, and the pending-entry flag for the serialiser.
module hiee_chan #(
  parameter int DW  = 32,
  parameter int TSW = 32,
  parameter int CW  = 32,
  parameter int HW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sample_valid,
  input  logic [TSW-1:0] ts_now,
  input  logic           en,
  input  logic [HW-1:0]  holdoff,
  input  logic [DW-1:0]  thresh,
  input  logic [DW-1:0]  hyst,
  input  logic [DW-1:0]  sample,
  input  logic           count_clr,
  input  logic           push,
  output logic           hit,
  output logic           pend,
  output logic [CW-1:0]  count,
  output logic [TSW-1:0] delta,
  output logic [TSW-1:0] ts_ch
);
  logic          armed;
  logic          has_hist;
  logic [HW-1:0] hold_cnt;
  logic [DW:0]   rearm_sum;

  // Widened sum so a large hysteresis can never wrap into a false re-arm.
  assign rearm_sum = {1'b0, sample} + {1'b0, hyst};
  assign hit = sample_valid && en && armed && (hold_cnt == '0) && (sample >= thresh);

  // Arm, holdoff and history state; a disabled channel is held in its idle state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed    <= 1'b1;
      hold_cnt <= '0;
      has_hist <= 1'b0;
    end else if (!en) begin
      armed    <= 1'b1;
      hold_cnt <= '0;
      has_hist <= 1'b0;
    end else if (hit) begin
      armed    <= 1'b0;
      hold_cnt <= holdoff;
      has_hist <= 1'b1;
    end else if (sample_valid) begin
      if (!armed && (rearm_sum < {1'b0, thresh})) armed <= 1'b1;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // Saturating hit counter; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n)                     count <= '0;
    else if (count_clr)             count <= '0;
    else if (hit && (count != '1))  count <= count + CW'(1);
  end

  // Delta and timestamp capture on hit; delta is 0 without prior history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delta <= '0;
      ts_ch <= '0;
    end else if (hit) begin
      delta <= has_hist ? (ts_now - ts_ch) : '0;
      ts_ch <= ts_now;
    end
  end

  // Pending flag: a hit (re)sets it even when the old entry is pushed this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)     pend <= 1'b0;
    else if (hit)   pend <= 1'b1;
    else if (push)  pend <= 1'b0;
  end
endmodule

module home_inventory_event_engine #(
  parameter int NCH   = 8,
  parameter int DW    = 32,
  parameter int TSW   = 32,
  parameter int CW    = 32,
  parameter int HW    = 16,
  parameter int DEPTH = 16,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [TSW-1:0]   ts_now,
  input  logic [NCH-1:0]   evt_en,
  input  logic [HW-1:0]    holdoff,
  input  logic [NCH*DW-1:0] thresh_flat,
  input  logic [NCH*DW-1:0] hyst_flat,
  input  logic [NCH*DW-1:0] sample_flat,
  input  logic             count_clr,
  output logic [NCH*CW-1:0]  evt_count_flat,
  output logic [NCH*TSW-1:0] last_delta_flat,
  output logic [NCH*TSW-1:0] last_ts_ch_flat,
  output logic [TSW-1:0]   last_ts,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CHW-1:0]   evt_ch,
  output logic [TSW-1:0]   evt_ts,
  output logic [TSW-1:0]   evt_delta,
  output logic [LW-1:0]    fifo_level,
  output logic [15:0]      ovf_count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [TSW-1:0] ts;
    logic [TSW-1:0] delta;
  } evt_t;

  logic [NCH-1:0]          hit, pend, push_vec, coal;
  logic [NCH-1:0][CW-1:0]  cnt;
  logic [NCH-1:0][TSW-1:0] delta, ts_ch;

  evt_t            mem [DEPTH];
  evt_t            push_data, head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, pop, push_ok, found;
  logic [16:0]     ovf_sum;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    hiee_chan #(.DW(DW), .TSW(TSW), .CW(CW), .HW(HW)) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .ts_now       (ts_now),
      .en           (evt_en[g]),
      .holdoff      (holdoff),
      .thresh       (thresh_flat[g*DW +: DW]),
      .hyst         (hyst_flat[g*DW +: DW]),
      .sample       (sample_flat[g*DW +: DW]),
      .count_clr    (count_clr),
      .push         (push_vec[g]),
      .hit          (hit[g]),
      .pend         (pend[g]),
      .count        (cnt[g]),
      .delta        (delta[g]),
      .ts_ch        (ts_ch[g])
    );
  end

  assign evt_count_flat  = cnt;
  assign last_delta_flat = delta;
  assign last_ts_ch_flat = ts_ch;

  assign full = (fifo_level == LW'(DEPTH));
  assign pop  = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = found && (!full || pop);

  // Serialiser: pick the lowest pending channel, payload from registered values.
  always_comb begin
    found     = 1'b0;
    push_vec  = '0;
    push_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pend[i] && !found) begin
        found       = 1'b1;
        push_vec[i] = push_ok;
        push_data   = '{ch: CHW'(i), ts: ts_ch[i], delta: delta[i]};
      end
    end
  end

  // Coalescing: hits landing on a still-pending, not-being-pushed channel.
  always_comb begin
    coal    = hit & pend & ~push_vec;
    ovf_sum = {1'b0, ovf_count};
    for (int i = 0; i < NCH; i++)
      if (coal[i]) ovf_sum = ovf_sum + 17'd1;
  end

  // Overflow counter, saturating; clear beats increment.
  always_ff @(posedge clk) begin
    if (!rst_n)         ovf_count <= '0;
    else if (count_clr) ovf_count <= '0;
    else                ovf_count <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  // Global timestamp of the most recent hit on any channel.
  always_ff @(posedge clk) begin
    if (!rst_n)     last_ts <= '0;
    else if (|hit)  last_ts <= ts_now;
  end

  // Event FIFO storage and pointers; reset clears contents so payload reads 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (fifo_level != '0);
  assign evt_ch    = head.ch;
  assign evt_ts    = head.ts;
  assign evt_delta = head.delta;
endmodule
